db9md_pad_scanner: RTL and testbench

- Upstream stage of the console's controller path: drives the SNAC DB9 Mega Drive pad lines (split/select) and decodes both pads into active-high 16-bit button words.
- Those words feed the OSD raw-joystick path and the per-player controller remap that produces the Coleco keypad/fire vectors.
- Time-multiplexes two pads on one 6-bit input bus via the split line.
- Runs the 8-phase Mega Drive select protocol per port, so 6-button pads are auto-detected.

---
 rtl/db9md_pad_scanner.sv | 228 ++++++++++++++++++++++
 tb/tb_db9md_pad_scanner.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/db9md_pad_scanner.sv
// db9md_pad_scanner: drives the DB9 split/select lines and decodes two
// Mega Drive pads (3- or 6-button, auto-detected) into active-high
// 16-bit button words. Port 1 is scanned first, then port 2, then select
// rests high long enough for 6-button pads to reset their phase counter.
//
// Build option: define DB9MD_DEBOUNCE_EN to publish a port's word (and its
// pad6 flag) only when two consecutive scans agree.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// SETTLE | one phase with select high after split changes, lines settle
// SCAN   | 8 select phases p=0..7, sample on the last cycle of each phase
// NEXT   | one-cycle junction after p7; shadow already committed, it also
//        | counts as the first cycle of the following SETTLE or IDLE
// IDLE   | select high for IDLE_CYC cycles, then back to port 1
module db9md_pad_scanner #(
  parameter int PHASE_CYC = 256,
  parameter int IDLE_CYC  = 40000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [5:0]  joy_in,
  output logic        joy_split,
  output logic        joy_mdsel,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic [1:0]  pad6,
  output logic        scan_done
);

  localparam int TW = (PHASE_CYC > 2) ? $clog2(PHASE_CYC) : 1;
  localparam int IW = (IDLE_CYC > 2) ? $clog2(IDLE_CYC) : 1;

  typedef enum logic [1:0] {
    S_SETTLE = 2'd0,
    S_SCAN   = 2'd1,
    S_NEXT   = 2'd2,
    S_IDLE   = 2'd3
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [TW-1:0]   r_timer;
  logic [TW-1:0]   w_timer_nxt;
  logic [IW-1:0]   r_idle;
  logic [IW-1:0]   w_idle_nxt;
  logic [2:0]      r_p;
  logic [2:0]      w_p_nxt;
  logic            r_split;
  logic            w_split_nxt;
  logic            r_mdsel;
  logic            w_mdsel_nxt;
  logic            w_phase_end;
  logic            w_idle_end;
  logic            w_commit;

  logic [5:0]      r_sync1;
  logic [5:0]      r_sync2;
  logic [5:0]      w_s;

  logic [11:0]     r_sh_word;
  logic            r_sh_present;
  logic            r_sh_six;
  logic [11:0]     w_new_word;
  logic            w_new_six;

  logic [11:0]     r_joy1;
  logic [11:0]     r_joy2;
  logic [1:0]      r_pad6;
  logic            r_scan_done;

`ifdef DB9MD_DEBOUNCE_EN
  logic [12:0]     r_prev1;
  logic [12:0]     r_prev2;
`endif

  assign w_s         = ~r_sync2;
  assign w_phase_end = (r_timer == TW'(PHASE_CYC - 1));
  assign w_idle_end  = (r_idle == IW'(IDLE_CYC - 1));

  // An absent pad reads as all-zero; a 3-button pad never reports X/Y/Z/Mode.
  assign w_new_six  = r_sh_present & r_sh_six;
  assign w_new_word = !r_sh_present ? 12'h000 :
                      (r_sh_six ? r_sh_word : {4'h0, r_sh_word[7:0]});

  // Next-state, timer and line control for the scan sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = w_phase_end ? '0 : r_timer + TW'(1);
    w_idle_nxt  = '0;
    w_p_nxt     = r_p;
    w_split_nxt = r_split;
    w_commit    = 1'b0;
    case (r_state)
      S_SETTLE: begin
        if (w_phase_end) begin
          w_state_nxt = S_SCAN;
          w_p_nxt     = 3'd0;
        end
      end
      S_SCAN: begin
        if (w_phase_end) begin
          if (r_p == 3'd7) begin
            w_state_nxt = S_NEXT;
            w_commit    = 1'b1;
            w_split_nxt = 1'b1;
          end else begin
            w_p_nxt = r_p + 3'd1;
          end
        end
      end
      S_NEXT: begin
        // scan_done is high here only when port 2 has just been committed.
        if (r_scan_done) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_idle_nxt  = IW'(1);
        end else begin
          w_state_nxt = S_SETTLE;
          w_timer_nxt = TW'(1);
        end
      end
      S_IDLE: begin
        w_timer_nxt = '0;
        if (w_idle_end) begin
          w_state_nxt = S_SETTLE;
          w_split_nxt = 1'b0;
        end else begin
          w_idle_nxt = r_idle + IW'(1);
        end
      end
      default: begin
        w_state_nxt = S_SETTLE;
        w_timer_nxt = '0;
      end
    endcase
    w_mdsel_nxt = (w_state_nxt == S_SCAN) ? ~w_p_nxt[0] : 1'b1;
  end

  // Sequencer registers, input synchronizer and registered pad lines.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_state <= S_SETTLE;
      r_timer <= '0;
      r_idle  <= '0;
      r_p     <= 3'd0;
      r_split <= 1'b0;
      r_mdsel <= 1'b1;
      r_sync1 <= 6'h3F;
      r_sync2 <= 6'h3F;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_idle  <= w_idle_nxt;
      r_p     <= w_p_nxt;
      r_split <= w_split_nxt;
      r_mdsel <= w_mdsel_nxt;
      r_sync1 <= joy_in;
      r_sync2 <= r_sync1;
    end
  end

  // Per-phase capture into the shadow word and commit to the port outputs.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_sh_word    <= '0;
      r_sh_present <= 1'b0;
      r_sh_six     <= 1'b0;
      r_joy1       <= '0;
      r_joy2       <= '0;
      r_pad6       <= '0;
      r_scan_done  <= 1'b0;
`ifdef DB9MD_DEBOUNCE_EN
      r_prev1      <= '0;
      r_prev2      <= '0;
`endif
    end else begin
      r_scan_done <= w_commit & r_split;
      if (r_state == S_SCAN && w_phase_end) begin
        case (r_p)
          3'd0: r_sh_word[5:0] <= {w_s[5], w_s[4], w_s[0], w_s[1], w_s[2], w_s[3]};
          3'd1: begin
            r_sh_word[7:6] <= {w_s[5], w_s[4]};
            r_sh_present   <= (r_sync2[3:2] == 2'b00);
          end
          3'd5: r_sh_six <= (r_sync2[3:0] == 4'h0);
          3'd6: r_sh_word[11:8] <= {w_s[0], w_s[1], w_s[2], w_s[3]};
          default: ;
        endcase
      end
      if (w_commit) begin
`ifdef DB9MD_DEBOUNCE_EN
        if (!r_split) begin
          if ({w_new_six, w_new_word} == r_prev1) begin
            r_joy1    <= w_new_word;
            r_pad6[0] <= w_new_six;
          end else begin
            r_prev1 <= {w_new_six, w_new_word};
          end
        end else begin
          if ({w_new_six, w_new_word} == r_prev2) begin
            r_joy2    <= w_new_word;
            r_pad6[1] <= w_new_six;
          end else begin
            r_prev2 <= {w_new_six, w_new_word};
          end
        end
`else
        if (!r_split) begin
          r_joy1    <= w_new_word;
          r_pad6[0] <= w_new_six;
        end else begin
          r_joy2    <= w_new_word;
          r_pad6[1] <= w_new_six;
        end
`endif
      end
    end
  end

  assign joy_split = r_split;
  assign joy_mdsel = r_mdsel;
  assign joystick1 = {4'h0, r_joy1};
  assign joystick2 = {4'h0, r_joy2};
  assign pad6      = r_pad6;
  assign scan_done = r_scan_done;

endmodule

// File: tb/tb_db9md_pad_scanner.sv
// Testbench for db9md_pad_scanner: two behavioural Mega Drive pads (none,
// 3-button or 6-button) on the split/select lines, expected button words
// derived from the pressed-button sets, directed steps plus random frames.
module tb_db9md_pad_scanner;

  localparam int P     = 8;
  localparam int IDLE  = 64;
  localparam int TMO   = 40;
  localparam int FRAME = 18 * P + IDLE;
  localparam int LIMIT = 2 * FRAME + 16;
  localparam int NONE  = 0;
  localparam int B3    = 1;
  localparam int B6    = 2;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic [5:0]  joy_in;
  logic        joy_split;
  logic        joy_mdsel;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic [1:0]  pad6;
  logic        scan_done;

  int          n_cmp = 0;
  int          n_mis = 0;

  int          typ  [2] = '{NONE, NONE};
  logic [11:0] btn  [2] = '{12'h000, 12'h000};
  int          lows [2] = '{0, 0};
  int          hirun[2] = '{0, 0};
  logic [1:0]  pad_sel;
  logic [1:0]  prev_sel = 2'b11;

  logic [15:0] exp_j1 = '0;
  logic [15:0] exp_j2 = '0;
  logic [1:0]  exp_p6 = '0;
  logic [16:0] prev1  = '0;
  logic [16:0] prev2  = '0;

  db9md_pad_scanner #(.PHASE_CYC(P), .IDLE_CYC(IDLE)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .joy_in    (joy_in),
    .joy_split (joy_split),
    .joy_mdsel (joy_mdsel),
    .joystick1 (joystick1),
    .joystick2 (joystick2),
    .pad6      (pad6),
    .scan_done (scan_done)
  );

  always #5 clk_sys = ~clk_sys;

  // A pad only sees select while the split line routes it to that port.
  assign pad_sel = {joy_split ? joy_mdsel : 1'b1, joy_split ? 1'b1 : joy_mdsel};

  // Pad line model. b uses the button-word layout.
  function automatic logic [5:0] pad_lines(int t, logic [11:0] b, logic sel, int n);
    if (t == NONE) return 6'h3F;
    if (sel) begin
      if (t == B6 && n == 3) return ~{b[5], b[4], b[8], b[9], b[10], b[11]};
      return ~{b[5], b[4], b[0], b[1], b[2], b[3]};
    end
    if (t == B6 && n == 3) return {~b[7], ~b[6], 4'b0000};
    if (t == B6 && n >= 4) return {~b[7], ~b[6], 4'b1111};
    return {~b[7], ~b[6], 2'b00, ~b[2], ~b[3]};
  endfunction

  assign joy_in = joy_split ? pad_lines(typ[1], btn[1], pad_sel[1], lows[1])
                            : pad_lines(typ[0], btn[0], pad_sel[0], lows[0]);

  // 6-button pad select counter: counts falling edges, clears after a long high.
  always @(posedge clk_sys) begin
    for (int k = 0; k < 2; k++) begin
      if (!pad_sel[k] && prev_sel[k] && lows[k] < 4) lows[k] <= lows[k] + 1;
      if (pad_sel[k]) begin
        hirun[k] <= hirun[k] + 1;
        if (hirun[k] >= TMO - 1) lows[k] <= 0;
      end else begin
        hirun[k] <= 0;
      end
    end
    prev_sel <= pad_sel;
  end

  function automatic logic [15:0] exp_word(int t, logic [11:0] b);
    if (t == B3) return {8'h00, b[7:0]};
    if (t == B6) return {4'h0, b};
    return 16'h0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_scan_done(output int n);
    n = 0;
    while (n < LIMIT) begin
      tick();
      n++;
      if (scan_done) break;
    end
    check("scan_done_seen", {31'd0, scan_done}, 32'd1);
  endtask

  task automatic model_reset();
    exp_j1 = '0;
    exp_j2 = '0;
    exp_p6 = '0;
    prev1  = '0;
    prev2  = '0;
  endtask

  // Advance the reference by one frame and compare all port outputs.
  task automatic check_frame(input string tag);
    logic [16:0] n1;
    logic [16:0] n2;
    n1 = {(typ[0] == B6), exp_word(typ[0], btn[0])};
    n2 = {(typ[1] == B6), exp_word(typ[1], btn[1])};
`ifdef DB9MD_DEBOUNCE_EN
    if (n1 == prev1) begin exp_j1 = n1[15:0]; exp_p6[0] = n1[16]; end
    else prev1 = n1;
    if (n2 == prev2) begin exp_j2 = n2[15:0]; exp_p6[1] = n2[16]; end
    else prev2 = n2;
`else
    exp_j1 = n1[15:0]; exp_p6[0] = n1[16];
    exp_j2 = n2[15:0]; exp_p6[1] = n2[16];
`endif
    check({tag, ".joystick1"}, {16'd0, joystick1}, {16'd0, exp_j1});
    check({tag, ".joystick2"}, {16'd0, joystick2}, {16'd0, exp_j2});
    check({tag, ".pad6"}, {30'd0, pad6}, {30'd0, exp_p6});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cyc;
    int first_low;
    logic [11:0] b;

    repeat (4) tick();
    check("rst.joystick1", {16'd0, joystick1}, 32'd0);
    check("rst.joystick2", {16'd0, joystick2}, 32'd0);
    check("rst.pad6", {30'd0, pad6}, 32'd0);
    check("rst.scan_done", {31'd0, scan_done}, 32'd0);
    check("rst.mdsel", {31'd0, joy_mdsel}, 32'd1);
    check("rst.split", {31'd0, joy_split}, 32'd0);

    // No pads: timing of the first frame measured from reset release.
    @(negedge clk_sys);
    reset = 1'b0;
    cyc = 0;
    first_low = -1;
    while (cyc < LIMIT) begin
      tick();
      cyc++;
      if (!joy_mdsel && first_low < 0) first_low = cyc;
      if (scan_done) break;
    end
    check("first_mdsel_low", 32'(first_low), 32'(2 * P));
    check("first_scan_done", 32'(cyc), 32'(18 * P));
    check_frame("nopad");
    tick();
    check("scan_done_width", {31'd0, scan_done}, 32'd0);
    wait_scan_done(n);
    check("frame_period", 32'(n + 1), 32'(FRAME));
    check_frame("nopad2");

    // 3-button pad on port 1 with Up+A.
    typ[0] = B3; btn[0] = 12'h048;
    wait_scan_done(n);
    check_frame("b3_upa");

    // 6-button pad on port 2 with C+Z+Mode.
    typ[1] = B6; btn[1] = 12'h920;
    wait_scan_done(n);
    check_frame("b6_czm");

    // Random pads and buttons, changed just after each scan_done.
    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 2; k++) begin
        typ[k] = int'($urandom_range(2, 0));
        b = 12'($urandom());
        if (typ[k] == B3 && b[3]) b[2] = 1'b0;
        btn[k] = b;
      end
      wait_scan_done(n);
      check_frame("rand");
      if (i % 3 == 2) begin
        wait_scan_done(n);
        check_frame("rand_hold");
      end
    end

    // Reset during port-2 p4 while port 1 holds Start.
    typ[0] = B3; btn[0] = 12'h080;
    typ[1] = B6; btn[1] = 12'h0F1;
    wait_scan_done(n);
    check_frame("start_pre");
    wait_scan_done(n);
    check_frame("start_pre2");
    repeat (IDLE + 14 * P + P / 2) tick();
    check("midscan.split_before", {31'd0, joy_split}, 32'd1);
    reset = 1'b1;
    tick();
    check("midscan.joystick1", {16'd0, joystick1}, 32'd0);
    check("midscan.joystick2", {16'd0, joystick2}, 32'd0);
    check("midscan.pad6", {30'd0, pad6}, 32'd0);
    check("midscan.mdsel", {31'd0, joy_mdsel}, 32'd1);
    check("midscan.split", {31'd0, joy_split}, 32'd0);
    model_reset();
    reset = 1'b0;
    wait_scan_done(n);
    check("midscan.restart_latency", 32'(n), 32'(18 * P));
    check_frame("after_reset");

`ifdef DB9MD_DEBOUNCE_EN
    // Toggling B never agrees across two scans; holding it does.
    typ[1] = NONE;
    for (int i = 0; i < 4; i++) begin
      btn[0] = (i % 2 == 0) ? 12'h010 : 12'h000;
      wait_scan_done(n);
      check_frame("db_toggle");
      check("db_toggle.const", {16'd0, joystick1}, 32'd0);
    end
    btn[0] = 12'h010;
    wait_scan_done(n);
    check_frame("db_hold1");
    wait_scan_done(n);
    check_frame("db_hold2");
    check("db_hold2.const", {16'd0, joystick1}, 32'h0010);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
